// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: redirect from the PC stage, the instruction-memory
// req/gnt/rvalid channel, and the valid/ready handoff to decode.
interface instr_fetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    // Fetch stage side.
    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc
    );

    // Environment side: PC stage, instruction memory and decode.
    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues in-order fetches, collects responses into a
// DEPTH-entry ring and hands {instr, instr_pc} to decode. A redirect flushes the
// ring and remembers how many in-flight responses must be thrown away.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 rst,
    instr_fetch_queue_if.master fq
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [CNT_W-1:0] alloc_cnt;
    logic [CNT_W-1:0] unfilled_cnt;
    logic [CNT_W-1:0] discard_cnt;
    logic [31:0]      slot_pc   [DEPTH];
    logic [31:0]      slot_data [DEPTH];

    logic [CNT_W:0]   committed;
    logic             grant;
    logic             drop;
    logic             fill;
    logic             pop;
    logic             head_filled;
    logic [1:0]       unused_pc_lsb;

    // Low address bits of a redirect target are ignored; fetches are word aligned.
    assign unused_pc_lsb = fq.redirect_pc[1:0];

    // Stale responses still in flight occupy capacity just like live slots.
    assign committed   = {1'b0, alloc_cnt} + {1'b0, discard_cnt};
    assign fq.imem_req = !rst && !fq.redirect && (committed < CAP);
    assign fq.imem_addr = fetch_pc;
    assign grant       = fq.imem_req && fq.imem_gnt;

    // Responses first pay off the discard debt, then fill the oldest unfilled slot.
    assign drop = fq.imem_rvalid && (discard_cnt != '0);
    assign fill = fq.imem_rvalid && (discard_cnt == '0) && (unfilled_cnt != '0);

    // Fills land in allocation order, so the head is filled whenever any slot is.
    assign head_filled    = (alloc_cnt != unfilled_cnt);
    assign fq.instr_valid = !rst && !fq.redirect && head_filled;
    assign fq.instr       = slot_data[head_ptr];
    assign fq.instr_pc    = slot_pc[head_ptr];
    assign pop            = fq.instr_valid && fq.instr_ready;

    // Fetch address, ring pointers and occupancy counts; redirect overrides grant/fill/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc     <= RESET_PC;
            head_ptr     <= '0;
            alloc_ptr    <= '0;
            fill_ptr     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
            discard_cnt  <= '0;
        end else if (fq.redirect) begin
            fetch_pc     <= {fq.redirect_pc[31:2], 2'b00};
            head_ptr     <= '0;
            alloc_ptr    <= '0;
            fill_ptr     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
            // A response landing in the redirect cycle is already stale.
            discard_cnt  <= discard_cnt + unfilled_cnt - CNT_W'(drop | fill);
        end else begin
            if (grant) begin
                fetch_pc  <= fetch_pc + 32'd4;
                alloc_ptr <= alloc_ptr + PTR_W'(1);
            end
            if (fill) begin
                fill_ptr <= fill_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            if (drop) begin
                discard_cnt <= discard_cnt - CNT_W'(1);
            end
            alloc_cnt    <= alloc_cnt + CNT_W'(grant) - CNT_W'(pop);
            unfilled_cnt <= unfilled_cnt + CNT_W'(grant) - CNT_W'(fill);
        end
    end

    // Slot payload storage; left unreset because occupancy lives in the counts.
    always_ff @(posedge clk) begin
        if (!rst && !fq.redirect) begin
            if (grant) begin
                slot_pc[alloc_ptr] <= fetch_pc;
            end
            if (fill) begin
                slot_data[fill_ptr] <= fq.imem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: an in-order memory with random
// latency, random decode back-pressure, redirects and resets, checked every
// cycle against a queue-level model of the fetch stage.
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          K_LIVE   = 0;
    localparam int          K_STALE  = 1;
    localparam int          K_DEAD   = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          filled;
    } entry_t;

    typedef struct {
        logic [31:0] data;
        int          due;
        int          kind;
    } resp_t;

    typedef struct {
        int          cycles;
        int          gnt_pct;
        int          rdy_pct;
        int          lat_min;
        int          lat_max;
        int          redir_pct;
        int          rst_pct;
        int          inj;
        logic [31:0] inj_pc;
    } phase_t;

    logic clk;
    logic rst;

    instr_fetch_queue_if fq ();

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    entry_t      mq[$];
    resp_t       pend[$];
    logic [31:0] m_pc;
    int          last_due;
    phase_t      phases[8];

    logic        r_rst, r_redir, r_gnt, r_ready, dlv;
    logic [31:0] r_rpc, r_rdata;
    int          dlv_kind;
    int          stale;
    bit          exp_req, exp_valid;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        //               cyc  gnt rdy lmin lmax redir rst inj  inj_pc
        phases[0] = '{  40, 100, 100, 1, 1,  0, 0, 0, 32'h0000_0000};
        phases[1] = '{  20, 100,   0, 1, 1,  0, 0, 0, 32'h0000_0000};
        phases[2] = '{  20, 100, 100, 1, 1,  0, 0, 0, 32'h0000_0000};
        phases[3] = '{  30, 100, 100, 3, 3,  0, 0, 1, 32'h0000_0103};
        phases[4] = '{  30,  20,  70, 1, 2,  0, 0, 0, 32'h0000_0000};
        phases[5] = '{  20, 100, 100, 1, 1,  0, 0, 1, 32'hFFFF_FFF9};
        phases[6] = '{  30, 100,  30, 1, 3,  0, 0, 2, 32'h0000_0000};
        phases[7] = '{3000,  70,  60, 1, 4,  5, 1, 0, 32'h0000_0000};

        rst             = 1'b1;
        fq.redirect     = 1'b0;
        fq.redirect_pc  = '0;
        fq.imem_gnt     = 1'b0;
        fq.imem_rvalid  = 1'b0;
        fq.imem_rdata   = '0;
        fq.instr_ready  = 1'b0;
        repeat (2) @(posedge clk);
        m_pc     = RESET_PC;
        last_due = 0;

        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < phases[p].cycles; k++) begin
                @(posedge clk);
                #1;
                cyc++;

                r_rst   = (phases[p].inj == 2 && k == 3) ||
                          ($urandom_range(99) < phases[p].rst_pct);
                r_redir = !r_rst && ((phases[p].inj == 1 && k == 3) ||
                          ($urandom_range(99) < phases[p].redir_pct));
                r_rpc   = (phases[p].inj == 1) ? phases[p].inj_pc : $urandom;
                // Pre-reset responses must drain before any new grant.
                r_gnt   = (pend.size() > 0 && pend[0].kind == K_DEAD) ? 1'b0 :
                          ($urandom_range(99) < phases[p].gnt_pct);
                r_ready = ($urandom_range(99) < phases[p].rdy_pct);

                // Capacity sees stale responses still pending at the start of the cycle.
                stale = 0;
                foreach (pend[i]) if (pend[i].kind == K_STALE) stale++;

                dlv      = 1'b0;
                dlv_kind = K_DEAD;
                r_rdata  = $urandom;
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    dlv      = 1'b1;
                    dlv_kind = pend[0].kind;
                    r_rdata  = pend[0].data;
                    void'(pend.pop_front());
                end

                rst            = r_rst;
                fq.redirect    = r_redir;
                fq.redirect_pc = r_rpc;
                fq.imem_gnt    = r_gnt;
                fq.imem_rvalid = dlv;
                fq.imem_rdata  = r_rdata;
                fq.instr_ready = r_ready;
                #1;

                exp_req   = !r_rst && !r_redir && (mq.size() + stale < DEPTH);
                exp_valid = !r_rst && !r_redir && mq.size() > 0 && mq[0].filled;
                chk_eq("imem_req", 32'(fq.imem_req), 32'(exp_req));
                chk_eq("imem_addr", fq.imem_addr, m_pc);
                chk_eq("instr_valid", 32'(fq.instr_valid), 32'(exp_valid));
                if (exp_valid) begin
                    chk_eq("instr_pc", fq.instr_pc, mq[0].pc);
                    chk_eq("instr", fq.instr, mq[0].data);
                end

                if (r_rst) begin
                    mq.delete();
                    m_pc = RESET_PC;
                    foreach (pend[i]) pend[i].kind = K_DEAD;
                end else if (r_redir) begin
                    mq.delete();
                    m_pc = {r_rpc[31:2], 2'b00};
                    foreach (pend[i]) if (pend[i].kind == K_LIVE) pend[i].kind = K_STALE;
                end else begin
                    if (exp_valid && r_ready) void'(mq.pop_front());
                    if (dlv && dlv_kind == K_LIVE) begin
                        for (int i = 0; i < mq.size(); i++) begin
                            if (!mq[i].filled) begin
                                mq[i].filled = 1'b1;
                                mq[i].data   = r_rdata;
                                break;
                            end
                        end
                    end
                    if (exp_req && r_gnt) begin
                        resp_t r;
                        entry_t e;
                        int lat;
                        e.pc     = m_pc;
                        e.data   = '0;
                        e.filled = 1'b0;
                        mq.push_back(e);
                        lat    = $urandom_range(phases[p].lat_max, phases[p].lat_min);
                        r.due  = cyc + lat;
                        if (r.due <= last_due) r.due = last_due + 1;
                        last_due = r.due;
                        r.data = ($urandom_range(1) == 1) ? $urandom : (m_pc ^ 32'hFFFF_0000);
                        r.kind = K_LIVE;
                        pend.push_back(r);
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
